// File: rtl/audio_timing_tdm_if.sv
// Control inputs and registered timing outputs of the fractional-N audio TDM
// timing generator. The generator drives the master side; serializers and
// the mixer observe the slave side.
interface audio_timing_tdm_if #(
    parameter int SLOTS         = 2,
    parameter int BITS_PER_SLOT = 16
);
    localparam int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int BIT_W  = (BITS_PER_SLOT > 1) ? $clog2(BITS_PER_SLOT) : 1;

    logic              enable;
    logic              rate_sel;
    logic              bclk;
    logic              fsync;
    logic              shift_strobe;
    logic              load_strobe;
    logic [SLOT_W-1:0] slot_index;
    logic [BIT_W-1:0]  bit_index;
    logic              sample_strobe;

    modport master (
        input  enable, rate_sel,
        output bclk, fsync, shift_strobe, load_strobe,
               slot_index, bit_index, sample_strobe
    );

    modport slave (
        output enable, rate_sel,
        input  bclk, fsync, shift_strobe, load_strobe,
               slot_index, bit_index, sample_strobe
    );
endinterface

// File: rtl/audio_timing_tdm.sv
// Fractional-N audio timing generator. A single phase accumulator produces
// BCLK edges from the system clock; frame position, frame sync and the
// serializer/mixer strobes are counted from BCLK falling edges, so they stay
// bit-aligned. Two selectable sample rates switch only at a frame wrap.
module audio_timing_tdm #(
    parameter int CLK_RATE      = 24_576_000,
    parameter int RATE0         = 48_000,
    parameter int RATE1         = 44_100,
    parameter int BITS_PER_SLOT = 16,
    parameter int SLOTS         = 2,
    parameter int FORMAT        = 0
) (
    input  logic               clk,
    input  logic               reset,
    audio_timing_tdm_if.master tdm
);
    localparam int FRAME_BITS = SLOTS * BITS_PER_SLOT;
    localparam int HALF       = FRAME_BITS / 2;
    localparam int ACC_W      = $clog2(CLK_RATE) + 1;
    localparam int POS_W      = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
    localparam int SLOT_W     = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int BIT_W      = (BITS_PER_SLOT > 1) ? $clog2(BITS_PER_SLOT) : 1;

    // BCLK edge rate (two edges per bit) for each selectable sample rate.
    localparam longint INC0_L = longint'(2) * longint'(RATE0) * longint'(FRAME_BITS);
    localparam longint INC1_L = longint'(2) * longint'(RATE1) * longint'(FRAME_BITS);

    localparam logic [ACC_W-1:0]  CLK_K     = ACC_W'(CLK_RATE);
    localparam logic [ACC_W-1:0]  INC0      = ACC_W'(INC0_L);
    localparam logic [ACC_W-1:0]  INC1      = ACC_W'(INC1_L);
    localparam logic [POS_W-1:0]  POS_LAST  = POS_W'(FRAME_BITS - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOTS - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(BITS_PER_SLOT - 1);

    if (INC0_L > longint'(CLK_RATE) || INC1_L > longint'(CLK_RATE)) begin : g_bad_rate
        $error("audio_timing_tdm: BCLK edge rate exceeds CLK_RATE");
    end
    if (FORMAT < 2 && (SLOTS % 2) != 0) begin : g_bad_slots
        $error("audio_timing_tdm: I2S/left-justified formats need an even SLOTS");
    end
    if (BITS_PER_SLOT < 2 || SLOTS < 1 || FORMAT < 0 || FORMAT > 3) begin : g_bad_shape
        $error("audio_timing_tdm: illegal BITS_PER_SLOT, SLOTS or FORMAT");
    end

    // Frame-sync level for a given (new) bit position.
    function automatic logic fsync_of(input logic [POS_W-1:0] p);
        int   pi;
        logic f;
        pi = int'(p);
        case (FORMAT)
            0:       f = (((pi + 1) % FRAME_BITS) >= HALF);
            1:       f = (pi >= HALF);
            2:       f = (pi == FRAME_BITS - 1);
            default: f = (pi == 0);
        endcase
        return f;
    endfunction

    logic [ACC_W-1:0]  acc_q, acc_d;
    logic              bclk_q, bclk_d;
    logic [POS_W-1:0]  pos_q, pos_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic              fsync_q, fsync_d;
    logic              shift_q, shift_d;
    logic              load_q, load_d;
    logic              sample_q, sample_d;
    logic              inc_sel_q, inc_sel_d;
    logic              pending_q, pending_d;

    logic [ACC_W-1:0]  inc_active;
    logic [ACC_W-1:0]  acc_sum;
    logic              edge_hit;
    logic              fall_hit;
    logic              wrap_hit;

    // acc < CLK_RATE and inc <= CLK_RATE, so the sum always fits ACC_W bits.
    assign inc_active = inc_sel_q ? INC1 : INC0;
    assign acc_sum    = acc_q + inc_active;
    assign edge_hit   = (acc_sum >= CLK_K);
    assign fall_hit   = edge_hit & bclk_q;
    assign wrap_hit   = fall_hit & (pos_q == POS_LAST);

    // Next state: accumulator step, BCLK edge handling, position/strobes, idle override.
    always_comb begin
        acc_d     = edge_hit ? (acc_sum - CLK_K) : acc_sum;
        bclk_d    = bclk_q ^ edge_hit;
        pos_d     = pos_q;
        slot_d    = slot_q;
        bit_d     = bit_q;
        fsync_d   = fsync_q;
        shift_d   = 1'b0;
        load_d    = 1'b0;
        sample_d  = 1'b0;
        inc_sel_d = inc_sel_q;
        pending_d = tdm.rate_sel;

        if (fall_hit) begin
            shift_d = 1'b1;
            if (bit_q == BIT_LAST) begin
                bit_d  = '0;
                load_d = 1'b1;
                slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + SLOT_W'(1);
            end else begin
                bit_d = bit_q + BIT_W'(1);
            end
            pos_d    = wrap_hit ? '0 : pos_q + POS_W'(1);
            sample_d = wrap_hit;
            fsync_d  = fsync_of(pos_d);
        end

        // The rate only changes where a new frame begins.
        if (wrap_hit) begin
            inc_sel_d = pending_q;
        end

        // Idle parks just before a wrap, with fsync already at its post-wrap
        // level, so restarting produces no spurious fsync transition.
        if (!tdm.enable) begin
            acc_d     = '0;
            bclk_d    = 1'b0;
            pos_d     = POS_LAST;
            slot_d    = SLOT_LAST;
            bit_d     = BIT_LAST;
            fsync_d   = fsync_of(POS_W'(0));
            shift_d   = 1'b0;
            load_d    = 1'b0;
            sample_d  = 1'b0;
            inc_sel_d = tdm.rate_sel;
        end
    end

    // State register; asynchronous reset lands in the idle state at RATE0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q     <= '0;
            bclk_q    <= 1'b0;
            pos_q     <= POS_LAST;
            slot_q    <= SLOT_LAST;
            bit_q     <= BIT_LAST;
            fsync_q   <= fsync_of(POS_W'(0));
            shift_q   <= 1'b0;
            load_q    <= 1'b0;
            sample_q  <= 1'b0;
            inc_sel_q <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            bclk_q    <= bclk_d;
            pos_q     <= pos_d;
            slot_q    <= slot_d;
            bit_q     <= bit_d;
            fsync_q   <= fsync_d;
            shift_q   <= shift_d;
            load_q    <= load_d;
            sample_q  <= sample_d;
            inc_sel_q <= inc_sel_d;
            pending_q <= pending_d;
        end
    end

    assign tdm.bclk          = bclk_q;
    assign tdm.fsync         = fsync_q;
    assign tdm.shift_strobe  = shift_q;
    assign tdm.load_strobe   = load_q;
    assign tdm.slot_index    = slot_q;
    assign tdm.bit_index     = bit_q;
    assign tdm.sample_strobe = sample_q;
endmodule

// File: doc/audio_timing_tdm.md
Name: audio_timing_tdm

Overview:
- Fractional-N audio timing generator; successor to the fixed stereo timing block.
- Derives BCLK from the fast system clock with a single phase accumulator. Frame sync and sample pulses are counted from BCLK, so they are always bit-aligned to it.
- Adds N-slot TDM, four frame formats, run-time selection between two sample rates (switched glitch-free at a frame boundary), and an enable/idle state.
- Drives the I2S/TDM serializers and the audio mixer sample tick.

Parameters:
- CLK_RATE, 24_576_000, input clk frequency in Hz.
- RATE0, 48_000, sample rate in Hz when rate_sel=0.
- RATE1, 44_100, sample rate in Hz when rate_sel=1.
- BITS_PER_SLOT, 16, BCLKs per slot (>=2).
- SLOTS, 2, slots per frame (>=1; must be even for FORMAT 0/1).
- FORMAT, 0, frame format: 0=I2S (1-bit delay), 1=left-justified, 2=DSP_A (1-bit pulse one bit before MSB), 3=DSP_B (1-bit pulse on MSB).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- enable  in  1  run when high; idle when low.
- rate_sel  in  1  selects RATE0/RATE1; takes effect at next frame wrap.
- bclk  out  1  bit clock.
- fsync  out  1  LRCLK (FORMAT 0/1) or frame-sync pulse (FORMAT 2/3).
- shift_strobe  out  1  1-clk pulse on every BCLK falling edge.
- load_strobe  out  1  1-clk pulse on the falling edge starting bit 0 (MSB) of each slot.
- slot_index  out  max(1,$clog2(SLOTS))  slot of the current bit.
- bit_index  out  max(1,$clog2(BITS_PER_SLOT))  bit within slot, 0=MSB.
- sample_strobe  out  1  load_strobe AND slot_index==0; exactly one per frame.

Behaviour:
Derived constants
- FRAME_BITS = SLOTS*BITS_PER_SLOT.
- INCk = 2*RATEk*FRAME_BITS (BCLK edge rate).
- Accumulator width = $clog2(CLK_RATE)+1.
- Elaboration error if INC0 or INC1 > CLK_RATE, or if FORMAT<2 with SLOTS odd.

Accumulator and edges
- Every clk while running: nxt = acc + inc_active.
- If nxt >= CLK_RATE: acc <= nxt - CLK_RATE and a BCLK edge occurs; otherwise acc <= nxt.
- Edges alternate rise/fall starting with rise after the idle state; at most one edge per clk.
- Jitter is bounded to ±1 clk per edge; there is no long-term drift.

Position counter
- pos runs 0..FRAME_BITS-1 and advances on each falling edge; it wraps FRAME_BITS-1 -> 0.
- slot_index = pos / BITS_PER_SLOT; bit_index = pos % BITS_PER_SLOT.

fsync as a function of the new pos (H = FRAME_BITS/2)
- FORMAT 0: high iff ((pos+1) mod FRAME_BITS) >= H (leads the MSB by one bit).
- FORMAT 1: high iff pos >= H.
- FORMAT 2: high iff pos == FRAME_BITS-1.
- FORMAT 3: high iff pos == 0.

Timing
- All outputs are registered.
- An edge decided in cycle n changes bclk, fsync, pos, and the strobes in cycle n+1.
- shift_strobe, load_strobe, and sample_strobe are high for exactly that one cycle.

Rate switching
- rate_sel is sampled every clk into pending_sel.
- inc_active is loaded from pending_sel only in the cycle where pos wraps to 0, so no partial frame runs at a mixed rate.
- acc is not cleared on a switch.

Enable
- enable low forces the idle state next clk: acc=0, bclk=0, pos=FRAME_BITS-1, fsync = formula(pos=0 after wrap) (so no spurious edge), strobes=0.
- inc_active loads the current rate_sel.
- On enable high, the first falling edge wraps pos to 0 and fires load_strobe and sample_strobe; this is the first frame.

Reset
- Asynchronous reset gives the same state as idle, except inc_active = INC0 and pending_sel = 0.
- Reset mid-frame abandons the frame immediately; no strobe is emitted in the reset cycle.

Simultaneous events
- enable falling on an edge cycle: idle wins; the edge is dropped.
- rate_sel toggling on the wrap cycle: the value registered in pending_sel before that cycle applies.

Test Plan:
- Defaults, 48k, FORMAT 0, enable=1 -> bclk toggles every 8 clk (period 16); sample_strobe every 512 clk; fsync changes at pos 15 and 31; load_strobe at pos 0 and 16.
- rate_sel=1 (44.1k) over 100 frames -> edge spacing 8 or 9 clk only; sample_strobe spacing 557 or 558; total clk count = floor/ceil of 100*557.28.
- rate_sel toggled mid-frame at pos 10 -> old spacing persists until pos wraps; new rate starts exactly at the next sample_strobe.
- SLOTS=8, BITS_PER_SLOT=32, FORMAT 2, 48k -> bclk toggles every clk; fsync high only for pos 255; slot_index 0..7; 8 load_strobes per frame, 1 sample_strobe.
- FORMAT 1 vs FORMAT 3, SLOTS=2 -> LJ: fsync rises at pos 16 with load_strobe. DSP_B: fsync is a 1-bit pulse at pos 0 only.
- Reset asserted at pos 20, and enable dropped mid-frame -> outputs go to idle values immediately (reset) or next clk (enable); after release, the first falling edge gives pos=0 with sample_strobe, and there is no extra fsync transition.
